srt_div_post: RTL and testbench

Post-processing stage directly downstream of the radix-2 SRT divider pipeline. It takes the raw SRT result:
- residual remainder, possibly negative and still scaled by the normalization shift
- non-redundant quotient
- normalized divisor, shift amount, operand sign flags

It applies the final correction, denormalizes the remainder and optionally fixes signs. Results are buffered in a small FIFO and presented to the consumer over a valid/ready handshake. The SRT pipeline cannot stall, so the block also raises an almost-full warning and a sticky overflow flag.

---
 rtl/srt_div_post_if.sv | 32 +++
 rtl/srt_div_post.sv | 131 +++++++++++++
 tb/tb_srt_div_post.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/srt_div_post_if.sv
// Bundle of the raw SRT result bus and the buffered result handshake for srt_div_post.
interface srt_div_post_if #(
  parameter int W   = 8,
  parameter int LDW = 3
);
  logic           raw_vld_i;
  logic [W-1:0]   raw_rem_i;
  logic [W-1:0]   raw_quo_i;
  logic [LDW-1:0] raw_ld_i;
  logic [W-1:0]   dvs_i;
  logic           op1_neg_i;
  logic           op2_neg_i;
  logic           dz_i;
  logic           vld_o;
  logic           rdy_i;
  logic [W-1:0]   quo_o;
  logic [W-1:0]   rem_o;
  logic           dz_o;
  logic           afull_o;
  logic           ovf_o;

  // Raw side has no backpressure; result side pops exactly on edges where vld_o & rdy_i,
  // and the payload is stable while vld_o is high and rdy_i is low.
  modport master (
    output raw_vld_i, raw_rem_i, raw_quo_i, raw_ld_i, dvs_i, op1_neg_i, op2_neg_i, dz_i, rdy_i,
    input  vld_o, quo_o, rem_o, dz_o, afull_o, ovf_o
  );
  modport slave (
    input  raw_vld_i, raw_rem_i, raw_quo_i, raw_ld_i, dvs_i, op1_neg_i, op2_neg_i, dz_i, rdy_i,
    output vld_o, quo_o, rem_o, dz_o, afull_o, ovf_o
  );
endinterface

// File: rtl/srt_div_post.sv
// SRT divider post-processing: residual correction, denormalisation, result FIFO.
// Define SRT_POST_SIGNED_EN to apply operand-sign fix-up to quotient and remainder.
module srt_div_post #(
  parameter int W        = 8,
  parameter int LDW      = 3,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 2
) (
  input logic           clk,
  input logic           rstn,
  srt_div_post_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam int EW = 2 * W + 1;

  logic           s1_vld, s1_dz;
  logic [W-1:0]   s1_rem, s1_quo;
  logic [LDW-1:0] s1_ld;
  logic           s2_vld;
  logic [EW-1:0]  s2_ent;
  logic [W-1:0]   shr, s2_quo_d, s2_rem_d;

`ifdef SRT_POST_SIGNED_EN
  logic s1_n1, s1_n2;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_n1 <= 1'b0;
      s1_n2 <= 1'b0;
    end else if (bus.raw_vld_i) begin
      s1_n1 <= bus.op1_neg_i;
      s1_n2 <= bus.op2_neg_i;
    end
  end
`else
  logic unused_neg;
  assign unused_neg = bus.op1_neg_i ^ bus.op2_neg_i;
`endif

  // A negative residual means the last quotient digit overshot by one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s1_rem <= '0;
      s1_quo <= '0;
      s1_ld  <= '0;
      s1_dz  <= 1'b0;
    end else begin
      s1_vld <= bus.raw_vld_i;
      if (bus.raw_vld_i) begin
        if (bus.raw_rem_i[W-1]) begin
          s1_rem <= bus.raw_rem_i + bus.dvs_i;
          s1_quo <= bus.raw_quo_i - W'(1);
        end else begin
          s1_rem <= bus.raw_rem_i;
          s1_quo <= bus.raw_quo_i;
        end
        s1_ld <= bus.raw_ld_i;
        s1_dz <= bus.dz_i;
      end
    end
  end

  assign shr = s1_rem >> s1_ld;

  always_comb begin
    s2_quo_d = s1_quo;
    s2_rem_d = shr;
`ifdef SRT_POST_SIGNED_EN
    if (s1_n1 ^ s1_n2) s2_quo_d = -s1_quo;
    if (s1_n1) s2_rem_d = -shr;
`endif
    if (s1_dz) begin
      s2_quo_d = '1;
      s2_rem_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld <= 1'b0;
      s2_ent <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_ent <= {s1_dz, s2_rem_d, s2_quo_d};
    end
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, vld, pop, wr, drop;
  logic [EW-1:0] head, last;

  assign full = (count == (AW+1)'(DEPTH));
  assign vld  = (count != '0);
  assign pop  = vld & bus.rdy_i;
  assign wr   = s2_vld & (~full | pop);
  assign drop = s2_vld & full & ~pop;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s2_ent;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last    <= '0;
      bus.afull_o <= 1'b0;
      bus.ovf_o   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (vld)  last <= head;
      if (drop) bus.ovf_o <= 1'b1;
      bus.afull_o <= (CW'(count) + CW'(s1_vld) + CW'(s2_vld)) >= CW'(AFULL_TH);
    end
  end

  // Once the FIFO drains, the last presented entry stays on the outputs.
  assign bus.vld_o = vld;
  assign {bus.dz_o, bus.rem_o, bus.quo_o} = vld ? head : last;
endmodule

// File: tb/tb_srt_div_post.sv
// Bench for srt_div_post: directed cases, backpressure/overflow, mid-stream reset, random traffic.
module tb_srt_div_post;
  localparam int W        = 8;
  localparam int LDW      = 3;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 2;
  localparam int MOD      = 1 << W;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  srt_div_post_if #(.W(W), .LDW(LDW)) bus ();

  srt_div_post #(.W(W), .LDW(LDW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: buffered results, in-flight results with their due edge, and shown value.
  logic [2*W:0] exp_q[$];
  logic [2*W:0] fly_q[$];
  int           fly_due[$];
  logic [2*W:0] hold;
  bit           m_afull;
  bit           m_ovf;
  int           cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] ref_result(input logic [W-1:0] rem, input logic [W-1:0] quo,
                                              input logic [LDW-1:0] ld, input logic [W-1:0] dvs,
                                              input bit n1, input bit n2, input bit dz);
    int r;
    int q;
    if (dz) return {1'b1, {W{1'b0}}, {W{1'b1}}};
    r = int'(rem);
    q = int'(quo);
    if (r >= MOD / 2) begin
      r = (r + int'(dvs)) % MOD;
      q = (q + MOD - 1) % MOD;
    end
    r = r / (1 << int'(ld));
`ifdef SRT_POST_SIGNED_EN
    if (n1 != n2) q = (MOD - q) % MOD;
    if (n1) r = (MOD - r) % MOD;
`else
    if (n1 && n2) r = r + 0;
`endif
    return {1'b0, W'(r), W'(q)};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    fly_q.delete();
    fly_due.delete();
    hold    = '0;
    m_afull = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit afull_next;
    bit was_full;
    bit popped;
    afull_next = (exp_q.size() + fly_q.size()) >= AFULL_TH;
    was_full   = (exp_q.size() == DEPTH);
    popped     = (exp_q.size() != 0) && bus.rdy_i;
    if (popped) void'(exp_q.pop_front());
    if (fly_q.size() != 0 && fly_due[0] == cyc) begin
      if (was_full && !popped) m_ovf = 1'b1;
      else exp_q.push_back(fly_q[0]);
      void'(fly_q.pop_front());
      void'(fly_due.pop_front());
    end
    if (bus.raw_vld_i) begin
      fly_q.push_back(ref_result(bus.raw_rem_i, bus.raw_quo_i, bus.raw_ld_i, bus.dvs_i,
                                 bus.op1_neg_i, bus.op2_neg_i, bus.dz_i));
      fly_due.push_back(cyc + 2);
    end
    if (exp_q.size() != 0) hold = exp_q[0];
    m_afull = afull_next;
    cyc++;
  endtask

  task automatic check_all();
    check("vld",   64'(bus.vld_o),   64'(exp_q.size() != 0));
    check("quo",   64'(bus.quo_o),   64'(hold[W-1:0]));
    check("rem",   64'(bus.rem_o),   64'(hold[2*W-1:W]));
    check("dz",    64'(bus.dz_o),    64'(hold[2*W]));
    check("afull", 64'(bus.afull_o), 64'(m_afull));
    check("ovf",   64'(bus.ovf_o),   64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_raw(input bit v, input logic [W-1:0] rem, input logic [W-1:0] quo,
                           input logic [LDW-1:0] ld, input logic [W-1:0] dvs,
                           input bit n1, input bit n2, input bit dz);
    bus.raw_vld_i = v;
    bus.raw_rem_i = rem;
    bus.raw_quo_i = quo;
    bus.raw_ld_i  = ld;
    bus.dvs_i     = dvs;
    bus.op1_neg_i = n1;
    bus.op2_neg_i = n2;
    bus.dz_i      = dz;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"},   64'(bus.vld_o),   64'(0));
    check({tag, "_quo"},   64'(bus.quo_o),   64'(0));
    check({tag, "_rem"},   64'(bus.rem_o),   64'(0));
    check({tag, "_dz"},    64'(bus.dz_o),    64'(0));
    check({tag, "_afull"}, 64'(bus.afull_o), 64'(0));
    check({tag, "_ovf"},   64'(bus.ovf_o),   64'(0));
  endtask

  // Issue one raw result, wait for it to reach the FIFO head, check it, then pop it.
  task automatic directed(input string tag, input logic [W-1:0] rem, input logic [W-1:0] quo,
                          input logic [LDW-1:0] ld, input logic [W-1:0] dvs, input bit n1,
                          input bit n2, input bit dz, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input bit edz);
    bus.rdy_i = 1'b0;
    drive_raw(1'b1, rem, quo, ld, dvs, n1, n2, dz);
    step();
    drive_raw(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check({tag, "_vld"}, 64'(bus.vld_o), 64'(1));
    check({tag, "_quo"}, 64'(bus.quo_o), 64'(eq));
    check({tag, "_rem"}, 64'(bus.rem_o), 64'(er));
    check({tag, "_dz"},  64'(bus.dz_o),  64'(edz));
    bus.rdy_i = 1'b1;
    step();
    bus.rdy_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    model_clear();
    rstn      = 1'b0;
    bus.rdy_i = 1'b0;
    drive_raw(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    step();

    directed("pos_resid", 8'h28, 8'd14, 3'd3, 8'h38, 1'b0, 1'b0, 1'b0, 8'd14, 8'd5, 1'b0);
    directed("neg_resid", 8'hF0, 8'd15, 3'd3, 8'h38, 1'b0, 1'b0, 1'b0, 8'd14, 8'd5, 1'b0);
`ifdef SRT_POST_SIGNED_EN
    directed("signed",    8'hF0, 8'd15, 3'd3, 8'h38, 1'b1, 1'b0, 1'b0, 8'hF2, 8'hFB, 1'b0);
`else
    directed("signed",    8'hF0, 8'd15, 3'd3, 8'h38, 1'b1, 1'b0, 1'b0, 8'd14, 8'd5, 1'b0);
`endif
    directed("div_zero",  8'h93, 8'h5A, 3'd2, 8'h40, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
    step();
    check("hold_after_drain_vld", 64'(bus.vld_o), 64'(0));
    check("hold_after_drain_quo", 64'(bus.quo_o), 64'(8'hFF));

    // Six back-to-back results into a depth-4 FIFO with the consumer stalled.
    bus.rdy_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_raw(1'b1, 8'h00, W'(i + 1), 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive_raw(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("bp_afull", 64'(bus.afull_o), 64'(1));
    check("bp_ovf",   64'(bus.ovf_o),   64'(1));
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_vld",   64'(bus.vld_o), 64'(1));
      check("bp_order", 64'(bus.quo_o), 64'(i + 1));
      step();
    end
    check("bp_empty",      64'(bus.vld_o), 64'(0));
    check("bp_ovf_sticky", 64'(bus.ovf_o), 64'(1));

    // Three buffered and two in flight, then reset.
    bus.rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_raw(1'b1, 8'h10, W'(8'h20 + i), 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive_raw(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("mid_buffered", 64'(exp_q.size()), 64'(3));
    #1 rstn = 1'b0;
    #1 check_zero("mid_reset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn      = 1'b1;
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("no_stale_vld", 64'(bus.vld_o), 64'(0));

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      drive_raw($urandom_range(0, 9) < 6, W'($urandom_range(0, MOD - 1)),
                W'($urandom_range(0, MOD - 1)), LDW'($urandom_range(0, W - 1)),
                W'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      bus.rdy_i = $urandom_range(0, 9) < 7;
      step();
    end
    drive_raw(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("drained", 64'(bus.vld_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
